// File: rtl/tick_scheduler_pkg.sv
// Shared definitions for the tick scheduler: FSM state encoding and
// default sizing constants.
package tick_sched_pkg;

  localparam int unsigned DEF_NREQ = 4;
  localparam int unsigned DEF_CW   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tick_scheduler_rr_arbiter.sv
// Stateless round-robin selector: scans the request vector starting at
// ptr and wrapping, reporting the first set index.
module rr_arbiter
  import tick_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  // First requester at or after ptr, modulo NREQ.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    winner = '0;
    valid  = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!valid && req[idx]) begin
        valid  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Shared-counter scheduler: grants one requester at a time, counts from 0
// up to the winner's sampled length, then pulses done with the winner id.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int CW   = DEF_CW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*CW-1:0]       len,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic [CW-1:0]            count,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id
);

  localparam int IW = $clog2(NREQ);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [CW-1:0] term;
  logic [IW-1:0] winner;
  logic          valid;
  logic [IW-1:0] next_ptr;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .valid  (valid)
  );

  // Index just past the current winner, wrapping at NREQ.
  always_comb begin
    next_ptr = (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);
  end

  // Scheduler FSM; the pointer advances at grant time so an abort also
  // moves priority past the aborted requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      count   <= '0;
      done    <= 1'b0;
      done_id <= '0;
      ptr     <= '0;
      owner   <= '0;
      term    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (valid) begin
            gnt   <= NREQ'(1) << winner;
            term  <= len[int'(winner)*CW +: CW];
            owner <= winner;
            ptr   <= next_ptr;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (!req[owner]) begin
            gnt   <= '0;
            count <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (count == term) begin
            gnt     <= '0;
            done    <= 1'b1;
            done_id <= owner;
            state   <= DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: tests queue expected grants and
// completions, a monitor pops and compares them as the DUT produces them.
module tb_tick_scheduler;

  localparam int NREQ = 4;
  localparam int CW   = 4;

  typedef struct {
    logic [NREQ-1:0] g;
    int              cyc;
  } gexp_t;

  typedef struct {
    logic [1:0]    id;
    logic [CW-1:0] cnt;
  } dexp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*CW-1:0]  len;
  logic [NREQ-1:0]     gnt;
  logic                busy;
  logic [CW-1:0]       count;
  logic                done;
  logic [1:0]          done_id;

  int n_cmp = 0;
  int n_bad = 0;

  gexp_t gq[$];
  dexp_t dq[$];

  always #5 clk = ~clk;

  tick_scheduler #(
    .NREQ (NREQ),
    .CW   (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .len     (len),
    .gnt     (gnt),
    .busy    (busy),
    .count   (count),
    .done    (done),
    .done_id (done_id)
  );

  // Monitor: checks each new grant, grant duration and each done pulse.
  logic [NREQ-1:0] prev_gnt = '0;
  int              run_cyc  = 0;
  int              cur_cyc  = -1;
  gexp_t           ge;
  dexp_t           de;

  always @(posedge clk) begin
    #2;
    if (gnt !== '0) begin
      if (prev_gnt === '0) begin
        n_cmp++;
        if (gq.size() == 0) begin
          n_bad++;
          cur_cyc = -1;
          $display("FAIL grant_unexpected: got %b, required no grant", gnt);
        end else begin
          ge = gq.pop_front();
          cur_cyc = ge.cyc;
          if (gnt !== ge.g) begin
            n_bad++;
            $display("FAIL grant_vector: got %b, required %b", gnt, ge.g);
          end
        end
        run_cyc = 0;
      end
      run_cyc++;
    end else if (prev_gnt !== '0 && cur_cyc >= 0) begin
      n_cmp++;
      if (run_cyc != cur_cyc) begin
        n_bad++;
        $display("FAIL grant_length: got %0d cycles, required %0d", run_cyc, cur_cyc);
      end
    end
    if (done === 1'b1) begin
      n_cmp++;
      if (dq.size() == 0) begin
        n_bad++;
        $display("FAIL done_unexpected: got done_id %0d, required no done", done_id);
      end else begin
        de = dq.pop_front();
        if (done_id !== de.id || count !== de.cnt) begin
          n_bad++;
          $display("FAIL done_value: got id %0d count %0d, required id %0d count %0d",
                   done_id, count, de.id, de.cnt);
        end
      end
    end
    prev_gnt = gnt;
  end

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    len = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (gnt !== '0)    begin n_bad++; $display("FAIL reset_gnt: got %b, required 0000", gnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_cmp++; if (count !== '0)  begin n_bad++; $display("FAIL reset_count: got %0d, required 0", count); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b, required 0", done); end
    n_cmp++; if (done_id !== '0) begin n_bad++; $display("FAIL reset_done_id: got %0d, required 0", done_id); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    len[0*CW +: CW] = 4'd3;
    req = 4'b0001;
    gq.push_back('{4'b0001, 4});
    dq.push_back('{2'd0, 4'd3});
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL single_gnt_latency: got %b, required 0001", gnt); end
    n_cmp++; if (busy !== 1'b1)   begin n_bad++; $display("FAIL single_busy_run: got %b, required 1", busy); end
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (count !== CW'(c)) begin n_bad++; $display("FAIL single_count: got %0d, required %0d", count, c); end
      @(negedge clk);
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL single_done: got %b, required 1", done); end
    n_cmp++; if (gnt !== '0)    begin n_bad++; $display("FAIL single_gnt_done: got %b, required 0000", gnt); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_done: got %b, required 1", busy); end
    req = '0;
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL single_idle: got done %b busy %b, required 0 0", done, busy);
    end
  endtask

  task automatic test_rotate();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    len = '0;
    req = 4'b1111;
    gq.push_back('{4'b0001, 1}); dq.push_back('{2'd0, 4'd0});
    gq.push_back('{4'b0010, 1}); dq.push_back('{2'd1, 4'd0});
    gq.push_back('{4'b0100, 1}); dq.push_back('{2'd2, 4'd0});
    gq.push_back('{4'b1000, 1}); dq.push_back('{2'd3, 4'd0});
    gq.push_back('{4'b0001, 1}); dq.push_back('{2'd0, 4'd0});
    repeat (14) @(negedge clk);
    n_cmp++; if (done !== 1'b1 || done_id !== 2'd0) begin
      n_bad++; $display("FAIL rotate_fifth_done: got done %b id %0d, required 1 0", done, done_id);
    end
    req = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (gq.size() != 0) begin n_bad++; $display("FAIL rotate_pending: got %0d grants left, required 0", gq.size()); end
  endtask

  task automatic test_max();
    len[2*CW +: CW] = 4'd15;
    req = 4'b0100;
    gq.push_back('{4'b0100, 16});
    dq.push_back('{2'd2, 4'd15});
    @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      n_cmp++;
      if (count !== CW'(c)) begin n_bad++; $display("FAIL max_count: got %0d, required %0d", count, c); end
      @(negedge clk);
    end
    n_cmp++; if (done !== 1'b1 || count !== 4'd15) begin
      n_bad++; $display("FAIL max_done_nowrap: got done %b count %0d, required 1 15", done, count);
    end
    req = '0;
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL max_single_pulse: got done %b busy %b, required 0 0", done, busy);
    end
  endtask

  task automatic test_abort();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    len = '0;
    len[1*CW +: CW] = 4'd8;
    req = 4'b0010;
    gq.push_back('{4'b0010, 5});
    repeat (5) @(negedge clk);
    n_cmp++; if (count !== 4'd4) begin n_bad++; $display("FAIL abort_reach4: got %0d, required 4", count); end
    req = '0;
    @(negedge clk);
    n_cmp++; if (gnt !== '0 || count !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle: got gnt %b count %0d busy %b done %b, required 0000 0 0 0",
                        gnt, count, busy, done);
    end
    len[1*CW +: CW] = 4'd0;
    req = 4'b0011;
    gq.push_back('{4'b0001, 1}); dq.push_back('{2'd0, 4'd0});
    gq.push_back('{4'b0010, 1}); dq.push_back('{2'd1, 4'd0});
    @(negedge clk);
    n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL abort_pointer: got %b, required 0001", gnt); end
    repeat (4) @(negedge clk);
    req = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (gq.size() != 0) begin n_bad++; $display("FAIL abort_pending: got %0d grants left, required 0", gq.size()); end
  endtask

  task automatic test_reset_mid();
    len[0*CW +: CW] = 4'd9;
    req = 4'b0001;
    gq.push_back('{4'b0001, 6});
    for (int i = 0; i < 20 && count !== 4'd5; i++) @(negedge clk);
    n_cmp++; if (count !== 4'd5) begin n_bad++; $display("FAIL rstmid_reach5: got %0d, required 5", count); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (gnt !== '0 || busy !== 1'b0 || count !== '0 || done !== 1'b0 || done_id !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: got gnt %b busy %b count %0d done %b id %0d, required 0000 0 0 0 0",
                        gnt, busy, count, done, done_id);
    end
    @(negedge clk);
    n_cmp++; if (gnt !== '0) begin n_bad++; $display("FAIL rstmid_override: got %b, required 0000", gnt); end
    rst = 1'b0;
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_len_change();
    len = '0;
    len[0*CW +: CW] = 4'd3;
    req = 4'b0001;
    gq.push_back('{4'b0001, 4});
    dq.push_back('{2'd0, 4'd3});
    @(negedge clk);
    len[0*CW +: CW] = 4'd9;
    req[2] = 1'b1;
    @(negedge clk);
    req[2] = 1'b0;
    for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
    n_cmp++; if (done !== 1'b1 || count !== 4'd3) begin
      n_bad++; $display("FAIL lenchg_done: got done %b count %0d, required 1 3", done, count);
    end
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_max();
    test_abort();
    test_reset_mid();
    test_len_change();
    repeat (3) @(negedge clk);
    n_cmp++; if (gq.size() != 0 || dq.size() != 0) begin
      n_bad++; $display("FAIL final_queues: got %0d grants %0d dones left, required 0 0", gq.size(), dq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
